ssp_tx_serializer: RTL and testbench

Transmit-side consumer of the SSP TX FIFO. It pops 8-bit words from the FIFO and shifts each one out MSB-first on a serial data line. Each word is preceded by a one-bit-period frame sync pulse and accompanied by a generated serial clock. It sits between the TX FIFO read port and the SSP pins.

---
 rtl/ssp_tx_serializer_pkg.sv | 24 ++
 rtl/ssp_tx_serializer_if.sv | 30 +++
 rtl/ssp_tx_serializer_bit_timer.sv | 47 ++++
 rtl/ssp_tx_serializer.sv | 153 +++++++++++++++
 tb/tb_ssp_tx_serializer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ssp_tx_serializer_pkg.sv
// Shared SSP definitions: FSM state encoding, default word width, phase-counter sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ssp_tx_serializer_pkg;

    localparam int SSP_WIDTH = 8;

    // Encoding is shared with the receive-side deserializer; keep values stable.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_FRAME = 3'd3,
        ST_SHIFT = 3'd4
    } ssp_state_e;

    // Phase counter spans 0 .. 2*half_period-1; never narrower than one bit.
    function automatic int phase_width(input int half_period);
        int w;
        w = $clog2(2 * half_period);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ssp_tx_serializer_if.sv
// Bundle of TX FIFO read-port and SSP pin signals around the serializer.
// Latency: n/a (wiring only).
// Backpressure: FIFO side signals availability with tx_empty; serializer pulls with tx_pop.
interface ssp_tx_serializer_if
    import ssp_tx_serializer_pkg::*;
#(
    parameter int WIDTH = SSP_WIDTH
);
    logic             en;
    logic             tx_empty;
    logic [WIDTH-1:0] tx_data;
    logic             tx_pop;
    logic             ssptxd;
    logic             sspclkout;
    logic             sspfssout;
    logic             sspoe_b;
    logic             busy;

    // Serializer side: consumes FIFO/control inputs, drives pop and pins.
    modport master (
        input  en, tx_empty, tx_data,
        output tx_pop, ssptxd, sspclkout, sspfssout, sspoe_b, busy
    );

    // Environment side: FIFO plus control, observes pins.
    modport slave (
        output en, tx_empty, tx_data,
        input  tx_pop, ssptxd, sspclkout, sspfssout, sspoe_b, busy
    );
endinterface

// File: rtl/ssp_tx_serializer_bit_timer.sv
// Bit-period timer: phase counter with ticks at end of high half and end of bit.
// Latency: ticks are decoded from the registered phase in the same cycle.
// Backpressure: none; free-runs while run_i is high, restarts on start_i.
module ssp_tx_serializer_bit_timer
    import ssp_tx_serializer_pkg::*;
#(
    parameter int HALF_PERIOD = 1
) (
    input  logic pclk,
    input  logic clear,
    input  logic start_i,
    input  logic run_i,
    output logic half_tick_o,
    output logic bit_tick_o
);
    localparam int            PW        = phase_width(HALF_PERIOD);
    localparam logic [PW-1:0] HALF_LAST = PW'(HALF_PERIOD - 1);
    localparam logic [PW-1:0] BIT_LAST  = PW'(2 * HALF_PERIOD - 1);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    assign half_tick_o = run_i && (phase_q == HALF_LAST);
    assign bit_tick_o  = run_i && (phase_q == BIT_LAST);

    // Next phase: hold at zero when stopped or restarting, wrap at end of bit.
    always_comb begin
        phase_d = phase_q;
        if (start_i || !run_i) begin
            phase_d = '0;
        end else if (bit_tick_o) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + 1'b1;
        end
    end

    // Phase register.
    always_ff @(posedge pclk or posedge clear) begin
        if (clear) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/ssp_tx_serializer.sv
// SSP transmit serializer: pops FIFO words, sends frame sync then MSB-first data with sspclkout.
// Latency: POP/LOAD take 2 cycles, then (WIDTH+1) bit periods of 2*HALF_PERIOD cycles each.
// Backpressure: pops only when en=1 and tx_empty=0 at IDLE or at the end of a word.
module ssp_tx_serializer
    import ssp_tx_serializer_pkg::*;
#(
    parameter int WIDTH       = SSP_WIDTH,
    parameter int HALF_PERIOD = 1
) (
    input  logic                pclk,
    input  logic                clear,
    ssp_tx_serializer_if.master bus
);
    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    ssp_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;

    logic tx_pop_q,    tx_pop_d;
    logic ssptxd_q,    ssptxd_d;
    logic sspclkout_q, sspclkout_d;
    logic sspfssout_q, sspfssout_d;
    logic sspoe_b_q,   sspoe_b_d;
    logic busy_q,      busy_d;

    logic timer_start;
    logic timer_run;
    logic half_tick;
    logic bit_tick;
    logic can_pop;
    logic next_serial;

    // Timer starts from phase 0 on FRAME entry and only runs while bits are on the line.
    assign timer_start = (state_q == ST_LOAD);
    assign timer_run   = (state_q == ST_FRAME) || (state_q == ST_SHIFT);
    assign can_pop     = bus.en && !bus.tx_empty;

    ssp_tx_serializer_bit_timer #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_bit_timer (
        .pclk        (pclk),
        .clear       (clear),
        .start_i     (timer_start),
        .run_i       (timer_run),
        .half_tick_o (half_tick),
        .bit_tick_o  (bit_tick)
    );

    // Next state, datapath next values, and next-cycle output decode.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;

        case (state_q)
            ST_IDLE: begin
                if (can_pop) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // FIFO data is valid the cycle after the pop request.
                shreg_d  = bus.tx_data;
                bitcnt_d = CNT_LAST;
                state_d  = ST_FRAME;
            end
            ST_FRAME: begin
                if (bit_tick) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_tick) begin
                    shreg_d = shreg_q << 1;
                    if (bitcnt_q == '0) begin
                        // Decision point: chain straight into the next word or go idle.
                        state_d = can_pop ? ST_POP : ST_IDLE;
                    end else begin
                        bitcnt_d = bitcnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from next-state values so they line up with the state.
        next_serial = (state_d == ST_FRAME) || (state_d == ST_SHIFT);
        tx_pop_d    = (state_d == ST_POP);
        busy_d      = (state_d != ST_IDLE);
        sspoe_b_d   = (state_d == ST_IDLE);
        sspfssout_d = (state_d == ST_FRAME);
        ssptxd_d    = (state_d == ST_SHIFT) ? shreg_d[WIDTH-1] : 1'b0;

        // Serial clock rises at the start of every bit period, falls at mid-bit.
        sspclkout_d = 1'b0;
        if (next_serial) begin
            if ((state_q == ST_LOAD) || bit_tick) begin
                sspclkout_d = 1'b1;
            end else if (half_tick) begin
                sspclkout_d = 1'b0;
            end else begin
                sspclkout_d = sspclkout_q;
            end
        end
    end

    // State register.
    always_ff @(posedge pclk or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shift register, bit counter and registered pin outputs.
    always_ff @(posedge pclk or posedge clear) begin
        if (clear) begin
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            tx_pop_q    <= 1'b0;
            ssptxd_q    <= 1'b0;
            sspclkout_q <= 1'b0;
            sspfssout_q <= 1'b0;
            sspoe_b_q   <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            tx_pop_q    <= tx_pop_d;
            ssptxd_q    <= ssptxd_d;
            sspclkout_q <= sspclkout_d;
            sspfssout_q <= sspfssout_d;
            sspoe_b_q   <= sspoe_b_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.tx_pop    = tx_pop_q;
    assign bus.ssptxd    = ssptxd_q;
    assign bus.sspclkout = sspclkout_q;
    assign bus.sspfssout = sspfssout_q;
    assign bus.sspoe_b   = sspoe_b_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ssp_tx_serializer.sv
// Bench for ssp_tx_serializer: FIFO model, scoreboard of expected words, waveform-shape monitor.
// Two instances: HALF_PERIOD=1 (dut_a) and HALF_PERIOD=3 (dut_b).
// Stimulus and checks are sampled away from the rising edge.
module tb_ssp_tx_serializer;
    import ssp_tx_serializer_pkg::*;

    localparam int H_A = 1;
    localparam int H_B = 3;

    logic pclk  = 1'b0;
    logic clear = 1'b1;
    int   cyc   = 0;

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    ssp_tx_serializer_if #(.WIDTH(8)) ifa ();
    ssp_tx_serializer_if #(.WIDTH(8)) ifb ();

    ssp_tx_serializer #(.WIDTH(8), .HALF_PERIOD(H_A)) dut_a (
        .pclk (pclk),
        .clear(clear),
        .bus  (ifa)
    );

    ssp_tx_serializer #(.WIDTH(8), .HALF_PERIOD(H_B)) dut_b (
        .pclk (pclk),
        .clear(clear),
        .bus  (ifb)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo_a[$];
    logic [7:0] fifo_b[$];
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    // Monitor bookkeeping, index 0 = dut_a, 1 = dut_b.
    int         pop_cnt[2]  = '{0, 0};
    int         last_pop[2] = '{0, 0};
    int         pop_gap[2]  = '{0, 0};
    int         idle_cyc[2] = '{0, 0};
    int         fss_cnt[2]  = '{0, 0};
    int         bc[2]       = '{0, 0};
    int         nbits[2]    = '{0, 0};
    int         falls[2]    = '{0, 0};
    logic       in_word[2]  = '{1'b0, 1'b0};
    logic       bitv[2]     = '{1'b0, 1'b0};
    logic       bit_ok[2]   = '{1'b1, 1'b1};
    logic       frame_ok[2] = '{1'b1, 1'b1};
    logic       prev_sclk[2] = '{1'b0, 1'b0};
    logic       prev_pop[2]  = '{1'b0, 1'b0};
    logic       prev_busy[2] = '{1'b0, 1'b0};
    logic [7:0] word[2]     = '{8'h00, 8'h00};

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // One monitor sample for one DUT; h is that DUT's HALF_PERIOD.
    task automatic mon_step(input int d, input int h, input logic busy, input logic fss,
                            input logic sclk, input logic txd, input logic pop, input logic oe_b);
        logic [7:0] exp_w;
        if (pop) begin
            chk("pop_single_cycle", prev_pop[d], 0);
            pop_cnt[d]++;
            pop_gap[d]  = cyc - last_pop[d];
            last_pop[d] = cyc;
        end
        if (prev_busy[d] && !busy) idle_cyc[d] = cyc;

        if (!busy) begin
            in_word[d]  = 1'b0;
            fss_cnt[d]  = 0;
            frame_ok[d] = 1'b1;
            chk("idle_outputs", {pop, txd, sclk, fss, oe_b}, 5'b00001);
        end else if (fss) begin
            if ((sclk != (fss_cnt[d] < h)) || txd) frame_ok[d] = 1'b0;
            fss_cnt[d]++;
        end else begin
            if (fss_cnt[d] != 0) begin
                chk("fss_len", fss_cnt[d], 2 * h);
                chk("frame_shape", frame_ok[d], 1);
                fss_cnt[d]  = 0;
                frame_ok[d] = 1'b1;
                in_word[d]  = 1'b1;
                bc[d]       = 0;
                nbits[d]    = 0;
                word[d]     = 8'h00;
                falls[d]    = 0;
                bit_ok[d]   = 1'b1;
            end
            if (in_word[d]) begin
                if (bc[d] == 0) bitv[d] = txd;
                else if (txd != bitv[d]) bit_ok[d] = 1'b0;
                if (sclk != (bc[d] < h)) bit_ok[d] = 1'b0;
                if (prev_sclk[d] && !sclk) falls[d]++;
                if (bc[d] == 2 * h - 1) begin
                    chk("bit_shape", bit_ok[d], 1);
                    word[d]   = {word[d][6:0], bitv[d]};
                    nbits[d]++;
                    bc[d]     = 0;
                    bit_ok[d] = 1'b1;
                    if (nbits[d] == 8) begin
                        in_word[d] = 1'b0;
                        chk("sclk_falls", falls[d], 8);
                        if ((d == 0) ? (exp_a.size() == 0) : (exp_b.size() == 0)) begin
                            chk("word_was_expected", 0, 1);
                        end else begin
                            exp_w = (d == 0) ? exp_a.pop_front() : exp_b.pop_front();
                            chk("serial_word", word[d], exp_w);
                        end
                    end
                end else begin
                    bc[d]++;
                end
            end else begin
                chk("gap_quiet", {sclk, txd}, 0);
            end
        end
        prev_sclk[d] = sclk;
        prev_pop[d]  = pop;
        prev_busy[d] = busy;
    endtask

    always @(negedge pclk) begin
        mon_step(0, H_A, ifa.busy, ifa.sspfssout, ifa.sspclkout, ifa.ssptxd, ifa.tx_pop, ifa.sspoe_b);
        mon_step(1, H_B, ifb.busy, ifb.sspfssout, ifb.sspclkout, ifb.ssptxd, ifb.tx_pop, ifb.sspoe_b);
    end

    function automatic logic pop_of(input int d);
        return (d == 0) ? ifa.tx_pop : ifb.tx_pop;
    endfunction

    function automatic logic busy_of(input int d);
        return (d == 0) ? ifa.busy : ifb.busy;
    endfunction

    // Advance one cycle and service the FIFO models (data presented right after the pop).
    task automatic step();
        @(posedge pclk);
        #1;
        if (ifa.tx_pop) begin
            chk("pop_only_when_nonempty_a", fifo_a.size() > 0, 1);
            if (fifo_a.size() > 0) ifa.tx_data = fifo_a.pop_front();
        end
        ifa.tx_empty = (fifo_a.size() == 0);
        if (ifb.tx_pop) begin
            chk("pop_only_when_nonempty_b", fifo_b.size() > 0, 1);
            if (fifo_b.size() > 0) ifb.tx_data = fifo_b.pop_front();
        end
        ifb.tx_empty = (fifo_b.size() == 0);
    endtask

    task automatic push_a(input logic [7:0] v, input bit expected);
        fifo_a.push_back(v);
        if (expected) exp_a.push_back(v);
        ifa.tx_empty = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] v, input bit expected);
        fifo_b.push_back(v);
        if (expected) exp_b.push_back(v);
        ifb.tx_empty = 1'b0;
    endtask

    task automatic wait_pop(input int d, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            if (pop_of(d)) done = 1'b1;
        end
        chk("wait_pop_timeout", done, 1);
    endtask

    // Wait for npops further pops and then a return to IDLE; settle monitor bookkeeping.
    task automatic wait_done(input int d, input int npops, input int budget);
        int seen = 0;
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            if (pop_of(d)) seen++;
            if (seen >= npops && !busy_of(d)) done = 1'b1;
        end
        chk("wait_done_timeout", done, 1);
        @(negedge pclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        int base;
        ifa.en = 1'b0; ifa.tx_empty = 1'b1; ifa.tx_data = 8'h00;
        ifb.en = 1'b0; ifb.tx_empty = 1'b1; ifb.tx_data = 8'h00;

        // 1. Reset, then enabled with an empty FIFO: nothing happens.
        repeat (3) step();
        chk("reset_outputs_a", {ifa.tx_pop, ifa.ssptxd, ifa.sspclkout, ifa.sspfssout, ifa.sspoe_b, ifa.busy}, 6'b000010);
        chk("reset_outputs_b", {ifb.tx_pop, ifb.ssptxd, ifb.sspclkout, ifb.sspfssout, ifb.sspoe_b, ifb.busy}, 6'b000010);
        clear  = 1'b0;
        ifa.en = 1'b1;
        repeat (30) step();
        chk("t1_no_pop_when_empty", pop_cnt[0], 0);

        // 2. Single word 0xA5: one pop, 20-cycle word time.
        base = pop_cnt[0];
        push_a(8'hA5, 1'b1);
        wait_done(0, 1, 60);
        chk("t2_pop_count", pop_cnt[0] - base, 1);
        chk("t2_word_time", idle_cyc[0] - last_pop[0], 20);

        // 3. Back-to-back 0x63, 0x61: pops 20 cycles apart.
        base = pop_cnt[0];
        push_a(8'h63, 1'b1);
        push_a(8'h61, 1'b1);
        wait_done(0, 2, 80);
        chk("t3_pop_count", pop_cnt[0] - base, 2);
        chk("t3_pop_spacing", pop_gap[0], 20);
        chk("t3_second_word_time", idle_cyc[0] - last_pop[0], 20);

        // 4. en dropped during bit 3 of 0x73 with another word waiting.
        base = pop_cnt[0];
        push_a(8'h73, 1'b1);
        push_a(8'h55, 1'b0);
        wait_pop(0, 20);
        repeat (10) step();
        ifa.en = 1'b0;
        wait_done(0, 0, 60);
        chk("t4_word_time", idle_cyc[0] - last_pop[0], 20);
        repeat (10) step();
        chk("t4_no_second_pop", pop_cnt[0] - base, 1);
        chk("t4_idle_after", ifa.busy, 0);
        fifo_a.delete();
        ifa.tx_empty = 1'b1;
        ifa.en       = 1'b1;

        // 5. Asynchronous clear during bit 5 of 0xFF, then a clean word.
        base = pop_cnt[0];
        push_a(8'hFF, 1'b0);
        wait_pop(0, 20);
        repeat (14) step();
        chk("t5_midword_busy", ifa.busy, 1);
        #1 clear = 1'b1;
        #1 chk("t5_async_reset_outputs",
               {ifa.tx_pop, ifa.ssptxd, ifa.sspclkout, ifa.sspfssout, ifa.sspoe_b, ifa.busy}, 6'b000010);
        #1 clear = 1'b0;
        repeat (5) step();
        chk("t5_no_repop", pop_cnt[0] - base, 1);
        push_a(8'h3C, 1'b1);
        wait_done(0, 1, 60);
        chk("t5_next_pop_count", pop_cnt[0] - base, 2);
        chk("t5_next_word_time", idle_cyc[0] - last_pop[0], 20);

        // 6. HALF_PERIOD=3, word 0x81: 56-cycle word time.
        push_b(8'h81, 1'b1);
        ifb.en = 1'b1;
        wait_done(1, 1, 120);
        chk("t6_pop_count", pop_cnt[1], 1);
        chk("t6_word_time", idle_cyc[1] - last_pop[1], 56);

        repeat (4) step();
        chk("exp_a_drained", exp_a.size(), 0);
        chk("exp_b_drained", exp_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
